// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and slice-count helper.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Number of RUN cycles needed to cover the operand width.
  function automatic int slices(input int width, input int bpc);
    return width / bpc;
  endfunction

endpackage

// File: rtl/serial_adder_slice.sv
// Combinational ripple of BITS_PER_CYCLE full-adder bits. Also exposes the
// carry into the top bit so the caller can form signed overflow.
module adder_slice #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [BITS_PER_CYCLE-1:0] a_i,
  input  logic [BITS_PER_CYCLE-1:0] b_i,
  input  logic                      c_i,
  output logic [BITS_PER_CYCLE-1:0] s_o,
  output logic                      c_o,
  output logic                      c_msb_o
);

  logic carry;

  // Ripple the carry bit by bit; a scalar running carry avoids a self-referencing vector.
  always_comb begin
    s_o     = '0;
    c_msb_o = 1'b0;
    carry   = c_i;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      s_o[i]  = a_i[i] ^ b_i[i] ^ carry;
      c_msb_o = carry;
      carry   = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    c_o = carry;
  end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle add/subtract: one adder_slice reused over WIDTH/BITS_PER_CYCLE
// cycles. Subtract is folded into the operand load (~b, ~cin) so the datapath
// only ever adds; cout is the raw carry (borrow = ~cout for subtract).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             overflow_o
);

  localparam int N  = slices(WIDTH, BITS_PER_CYCLE);
  localparam int CW = $clog2(N) + 1;

  if ((WIDTH < 2) || (BITS_PER_CYCLE < 1) || ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_cfg
    $error("serial_adder: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
  end

  logic [1:0]                state_q, state_d;
  logic [WIDTH-1:0]          a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic                      carry_q, carry_d;
  logic [CW-1:0]             k_q, k_d;
  logic                      cout_q, cout_d, ovf_q, ovf_d;
  logic [BITS_PER_CYCLE-1:0] sl_a, sl_b, sl_s;
  logic                      sl_c, sl_cmsb;

  // Select slice k of each operand; constant-index decode keeps widths exact.
  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int j = 0; j < N; j++) begin
      if (k_q == CW'(j)) begin
        sl_a = a_q[j*BITS_PER_CYCLE +: BITS_PER_CYCLE];
        sl_b = b_q[j*BITS_PER_CYCLE +: BITS_PER_CYCLE];
      end
    end
  end

  adder_slice #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_slice (
    .a_i    (sl_a),
    .b_i    (sl_b),
    .c_i    (carry_q),
    .s_o    (sl_s),
    .c_o    (sl_c),
    .c_msb_o(sl_cmsb)
  );

  // FSM and datapath next state: load on accepted start, one slice per RUN cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    k_d     = k_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = sub_i ? ~b_i : b_i;
          carry_d = cin_i ^ sub_i;
          k_d     = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        for (int j = 0; j < N; j++) begin
          if (k_q == CW'(j)) sum_d[j*BITS_PER_CYCLE +: BITS_PER_CYCLE] = sl_s;
        end
        carry_d = sl_c;
        k_d     = k_q + CW'(1);
        if (k_q == CW'(N - 1)) begin
          cout_d  = sl_c;
          ovf_d   = sl_cmsb ^ sl_c;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o     = (state_q == ST_RUN);
  assign done_o     = (state_q == ST_DONE);
  assign sum_o      = sum_q;
  assign cout_o     = cout_q;
  assign overflow_o = ovf_q;

endmodule
